iq_sample_unpacker: RTL and testbench
=====================================

# iq_sample_unpacker

Front-end stage directly upstream of `acquisition`. It converts a free-running stream of interleaved 16-bit I/Q words into paired complex samples `i_out`/`q_out`, with optional byte-order correction. Pairs are buffered in a small FIFO and delivered on a valid/ready interface. Dropped data and realignment events are counted for debug.

## Interface

Parameters:
- `DATA_W`, 16: sample width. This also sets the input word width.
- `FIFO_DEPTH`, 8: number of buffered I/Q pairs. Must be a power of 2 and at least 2.
- `CNT_W`, 16: width of `overflow_cnt`.

Ports:
- `clk`  in  1: sole clock.
- `reset`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: input word present. There is no backpressure toward the source.
- `in_word`  in  DATA_W: interleaved sample word (I, Q, I, Q…).
- `in_sync`  in  1: qualified by `in_valid`. Marks `in_word` as an I word.
- `out_valid`  out  1: FIFO head pair is valid.
- `out_ready`  in  1: consumer accepts the head pair.
- `i_out`  out  DATA_W: head I sample.
- `q_out`  out  DATA_W: head Q sample.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1: number of stored pairs.
- `overflow_cnt`  out  CNT_W: count of pairs dropped because the FIFO was full. Saturating.
- `resync_cnt`  out  8: count of `in_sync` events that discarded a pending I word. Saturating.

## Operation

Pairing state machine, `st`:
- **WAIT_I**: on `in_valid`, latch the word into `i_hold` and go to HAVE_I.
- **HAVE_I**, `in_valid` with `in_sync`=0: the word is Q. Push `{i_hold, word}` into the FIFO, or drop it (see below). Return to WAIT_I.
- **HAVE_I**, `in_valid` with `in_sync`=1: discard `i_hold` and latch the new word as I. Stay in HAVE_I. Increment `resync_cnt`.
- **WAIT_I**, `in_valid` with `in_sync`=1: normal I latch. No count.
- Any state with `in_valid`=0: hold state.

Push and pop rules:
- Pop occurs on `out_valid && out_ready`.
- Push is permitted if `fifo_level < FIFO_DEPTH`, or if a pop happens in the same cycle. A full FIFO with a simultaneous pop accepts the new pair with no loss.
- A Q word that arrives when push is not permitted drops the whole pair. `overflow_cnt` increments and the state returns to WAIT_I.
- `fifo_level` equals pushes minus pops. A same-cycle push and pop leaves it unchanged.

Other rules:
- No arithmetic is applied to sample values. Words pass bit-exact, after the optional byte swap.
- Both counters saturate at all-ones and never wrap. They are cleared only by reset.
- The pointer wrap at `FIFO_DEPTH` is natural binary. This is why the depth must be a power of 2.

## Timing

Reset values:
- `out_valid`=0, `i_out`=0, `q_out`=0.
- `fifo_level`=0, `overflow_cnt`=0, `resync_cnt`=0.
- `st`=WAIT_I, `i_hold`=0.

Cycle behaviour:
- Latency: a Q word accepted at edge N into an empty FIFO gives `out_valid`=1 with the pair at `i_out`/`q_out` in the cycle after edge N.
- The FIFO is show-ahead: the head is stable on outputs while `out_valid`=1 and `out_ready`=0.
- After a pop at edge M, the next head appears in the cycle after M if the FIFO is non-empty. Otherwise `out_valid` drops.
- Throughput: one pair per two input words. The output side can sustain one pop per cycle.
- `in_valid` may be asserted on every cycle.
- Reset asserted mid-operation: all state clears immediately (asynchronous assertion). Stored pairs and any pending I word are lost.
- Reset deassertion is synchronised externally. The first `in_valid` after reset is treated as I.

## Configuration

- `IQ_BYTE_SWAP_EN` defined: each `in_word` has its bytes exchanged (`[7:0]`↔`[15:8]`) before pairing. This converts little-endian sample files and front-ends to the internal order. Requires `DATA_W`=16.
- `IQ_BYTE_SWAP_EN` undefined: `in_word` is used unchanged.

## Structure

- Shared package `iq_pkg`:
  - `iq_pair_t`, a packed struct `{i, q}` of `DATA_W` each.
  - `unpack_state_t`, enum {WAIT_I, HAVE_I}.
  - Default-width constants.
- One sub-module `iq_sync_fifo`:
  - Parameterised on element type and depth.
  - Show-ahead read, with the same-cycle push-when-full-with-pop rule.
  - Provides `fifo_level`.
- The top level holds the byte swap, the pairing FSM and both counters.

## Test plan

All directed cases use `FIFO_DEPTH`=8.
- **Reset check**: hold `reset`=0, then inspect outputs → all outputs 0 and `out_valid`=0.
- **Single pair**: with the macro on, drive words 0x3412, 0xCDAB and keep `out_ready`=1 → exactly one cycle after the Q edge, `out_valid`=1 with `i_out`=0x1234, `q_out`=0xABCD. With the macro off, the same words give `i_out`=0x3412, `q_out`=0xCDAB.
- **Overflow**: hold `out_ready`=0 and send 20 back-to-back words → `fifo_level`=8, `overflow_cnt`=2. Draining yields the first 8 pairs in order.
- **Resync**: send I=0x0001, then 0x0002 with `in_sync`=1, then 0x0003 → a single pair (0x0002, 0x0003) and `resync_cnt`=1.
- **Full plus pop**: with the FIFO full, pulse `out_ready`=1 in the same cycle as a Q word → no drop, `overflow_cnt` unchanged, `fifo_level` stays 8.
- **Reset mid-stream**: assert reset with 5 pairs stored and an I word pending → `fifo_level`=0 and `out_valid`=0 immediately. After release, the words 0x0A, 0x0B pair as I=0x0A, Q=0x0B.

Source files
------------

// File: rtl/iq_pkg.sv
// Shared types and default widths for the I/Q sample unpacker.
// The byte-swap feature is selected at build time with the IQ_BYTE_SWAP_EN macro.
package iq_pkg;

    localparam int IQ_DATA_W     = 16;
    localparam int IQ_FIFO_DEPTH = 8;
    localparam int IQ_CNT_W      = 16;
    localparam int IQ_RESYNC_W   = 8;

    // One complex sample at the default width
    typedef struct packed {
        logic [IQ_DATA_W-1:0] i;
        logic [IQ_DATA_W-1:0] q;
    } iq_pair_t;

    // Pairing state: waiting for an I word, or holding one and waiting for Q
    typedef enum logic {
        WAIT_I = 1'b0,
        HAVE_I = 1'b1
    } unpack_state_t;

endpackage

// File: rtl/iq_sample_unpacker_if.sv
// Sample stream bundle: interleaved word input (no backpressure) and
// valid/ready paired output. slave = unpacker side, master = source/sink side.
interface iq_sample_unpacker_if #(
    parameter int DATA_W = 16
) ();

    logic              in_valid;
    logic [DATA_W-1:0] in_word;
    logic              in_sync;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] i_out;
    logic [DATA_W-1:0] q_out;

    modport slave (
        input  in_valid, in_word, in_sync, out_ready,
        output out_valid, i_out, q_out
    );

    modport master (
        output in_valid, in_word, in_sync, out_ready,
        input  out_valid, i_out, q_out
    );

endinterface

// File: rtl/iq_sync_fifo.sv
// Show-ahead synchronous FIFO of arbitrary packed elements.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// Pointers wrap naturally, so DEPTH must be a power of 2.
module iq_sync_fifo
    import iq_pkg::*;
#(
    parameter type T     = iq_pair_t,
    parameter int  DEPTH = IQ_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output logic                     can_push,
    output logic                     empty,
    output T                         head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic          do_push;
    logic          do_pop;

    assign empty    = (level_reg == '0);
    assign do_pop   = pop && !empty;
    assign can_push = (level_reg != LW'(DEPTH)) || do_pop;
    assign do_push  = push && can_push;
    assign level    = level_reg;

    // Storage write; contents need no reset because level gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves level unchanged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Show-ahead head; forced to zero when nothing is stored
    always_comb begin
        head = '0;
        if (!empty) head = mem[rd_ptr_reg];
    end

endmodule

// File: rtl/iq_sample_unpacker.sv
// Pairs a free-running interleaved I/Q word stream into complex samples,
// buffers them in a small FIFO and counts dropped pairs and resyncs.
// Define IQ_BYTE_SWAP_EN to exchange the two bytes of every input word
// (requires DATA_W = 16).
module iq_sample_unpacker
    import iq_pkg::*;
#(
    parameter int DATA_W     = IQ_DATA_W,
    parameter int FIFO_DEPTH = IQ_FIFO_DEPTH,
    parameter int CNT_W      = IQ_CNT_W
) (
    input  logic                          clk,
    input  logic                          reset,
    iq_sample_unpacker_if.slave           bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              overflow_cnt,
    output logic [IQ_RESYNC_W-1:0]        resync_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] i;
        logic [DATA_W-1:0] q;
    } pair_t;

    unpack_state_t          st_reg, st_next;
    logic [DATA_W-1:0]      i_hold_reg, i_hold_next;
    logic [DATA_W-1:0]      word;
    logic                   q_arrived;
    logic                   resync;
    logic                   can_push;
    logic                   drop;
    logic                   fifo_empty;
    pair_t                  push_pair;
    pair_t                  head_pair;
    logic [CNT_W-1:0]       overflow_cnt_reg;
    logic [IQ_RESYNC_W-1:0] resync_cnt_reg;

`ifdef IQ_BYTE_SWAP_EN
    assign word = {bus.in_word[7:0], bus.in_word[15:8]};
`else
    assign word = bus.in_word;
`endif

    // Pairing decisions: latch I, complete a pair on Q, or restart on sync
    always_comb begin
        st_next     = st_reg;
        i_hold_next = i_hold_reg;
        q_arrived   = 1'b0;
        resync      = 1'b0;
        if (bus.in_valid) begin
            case (st_reg)
                WAIT_I: begin
                    i_hold_next = word;
                    st_next     = HAVE_I;
                end
                HAVE_I: begin
                    if (bus.in_sync) begin
                        i_hold_next = word;
                        resync      = 1'b1;
                    end else begin
                        q_arrived = 1'b1;
                        st_next   = WAIT_I;
                    end
                end
                default: st_next = WAIT_I;
            endcase
        end
    end

    // Pairing state and pending I word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_reg     <= WAIT_I;
            i_hold_reg <= '0;
        end else begin
            st_reg     <= st_next;
            i_hold_reg <= i_hold_next;
        end
    end

    assign push_pair = '{i: i_hold_reg, q: word};
    assign drop      = q_arrived && !can_push;

    iq_sync_fifo #(
        .T     (pair_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (q_arrived),
        .push_data (push_pair),
        .pop       (bus.out_ready),
        .can_push  (can_push),
        .empty     (fifo_empty),
        .head      (head_pair),
        .level     (fifo_level)
    );

    // Saturating debug counters, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_cnt_reg <= '0;
            resync_cnt_reg   <= '0;
        end else begin
            if (drop && (overflow_cnt_reg != '1))
                overflow_cnt_reg <= overflow_cnt_reg + CNT_W'(1);
            if (resync && (resync_cnt_reg != '1))
                resync_cnt_reg <= resync_cnt_reg + IQ_RESYNC_W'(1);
        end
    end

    assign bus.out_valid = !fifo_empty;
    assign bus.i_out     = head_pair.i;
    assign bus.q_out     = head_pair.q;
    assign overflow_cnt  = overflow_cnt_reg;
    assign resync_cnt    = resync_cnt_reg;

endmodule

// File: tb/tb_iq_sample_unpacker.sv
// Directed testbench for iq_sample_unpacker (FIFO_DEPTH = 8).
// Expected sample values follow IQ_BYTE_SWAP_EN when it is defined.
module tb_iq_sample_unpacker;

    logic        clk;
    logic        reset;
    logic [3:0]  fifo_level;
    logic [15:0] overflow_cnt;
    logic [7:0]  resync_cnt;

    int checks = 0;
    int errors = 0;

    iq_sample_unpacker_if #(.DATA_W(16)) bus ();

    iq_sample_unpacker #(
        .DATA_W     (16),
        .FIFO_DEPTH (8),
        .CNT_W      (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .fifo_level   (fifo_level),
        .overflow_cnt (overflow_cnt),
        .resync_cnt   (resync_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] w;
        logic        s;
        logic        r;
        logic        ev;
        logic [15:0] ei;
        logic [15:0] eq;
        int          elvl;
        int          ers;
    } vec_t;

    vec_t tbl [13];

    function automatic logic [15:0] xw(input logic [15:0] w);
`ifdef IQ_BYTE_SWAP_EN
        return {w[7:0], w[15:8]};
`else
        return w;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] w, input logic s, input logic r);
        bus.in_valid  = v;
        bus.in_word   = w;
        bus.in_sync   = s;
        bus.out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pair(input string name, input logic [15:0] ei, input logic [15:0] eq);
        chk({name, " out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, " i_out"}, 32'(bus.i_out), 32'(ei));
        chk({name, " q_out"}, 32'(bus.q_out), 32'(eq));
    endtask

    logic [15:0] ei, eq;

    initial begin
        reset = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);

        // Reset state
        tick();
        tick();
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset i_out", 32'(bus.i_out), 32'd0);
        chk("reset q_out", 32'(bus.q_out), 32'd0);
        chk("reset fifo_level", 32'(fifo_level), 32'd0);
        chk("reset overflow_cnt", 32'(overflow_cnt), 32'd0);
        chk("reset resync_cnt", 32'(resync_cnt), 32'd0);
        $display("reset: out_valid=%0b level=%0d", bus.out_valid, fifo_level);
        reset = 1'b1;
        tick();

        // Single pair, resync, show-ahead hold
        tbl[0]  = '{1'b1, 16'h3412, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 0, 0};
        tbl[1]  = '{1'b1, 16'hCDAB, 1'b0, 1'b1, 1'b1, xw(16'h3412), xw(16'hCDAB), 1, 0};
        tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 0, 0};
        tbl[3]  = '{1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 0, 0};
        tbl[4]  = '{1'b1, 16'h0002, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 0, 1};
        tbl[5]  = '{1'b1, 16'h0003, 1'b0, 1'b1, 1'b1, xw(16'h0002), xw(16'h0003), 1, 1};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 0, 1};
        tbl[7]  = '{1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 0, 1};
        tbl[8]  = '{1'b1, 16'h2222, 1'b0, 1'b1, 1'b1, xw(16'h1111), xw(16'h2222), 1, 1};
        tbl[9]  = '{1'b1, 16'h3333, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 0, 1};
        tbl[10] = '{1'b1, 16'h4444, 1'b0, 1'b0, 1'b1, xw(16'h3333), xw(16'h4444), 1, 1};
        tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, xw(16'h3333), xw(16'h4444), 1, 1};
        tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 0, 1};

        for (int n = 0; n < 13; n++) begin
            drive(tbl[n].v, tbl[n].w, tbl[n].s, tbl[n].r);
            tick();
            $display("vec %0d: v=%0b w=%04h s=%0b r=%0b -> out_valid=%0b i=%04h q=%04h level=%0d resync=%0d",
                     n, tbl[n].v, tbl[n].w, tbl[n].s, tbl[n].r,
                     bus.out_valid, bus.i_out, bus.q_out, fifo_level, resync_cnt);
            chk($sformatf("vec%0d out_valid", n), 32'(bus.out_valid), 32'(tbl[n].ev));
            if (tbl[n].ev) begin
                chk($sformatf("vec%0d i_out", n), 32'(bus.i_out), 32'(tbl[n].ei));
                chk($sformatf("vec%0d q_out", n), 32'(bus.q_out), 32'(tbl[n].eq));
            end
            chk($sformatf("vec%0d fifo_level", n), 32'(fifo_level), 32'(tbl[n].elvl));
            chk($sformatf("vec%0d resync_cnt", n), 32'(resync_cnt), 32'(tbl[n].ers));
        end
        chk("table overflow_cnt", 32'(overflow_cnt), 32'd0);

        // Overflow: 20 words with no consumer, two pairs dropped
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 16'h0100 + 16'(k), (k % 2) == 0, 1'b0);
            tick();
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        $display("overflow: level=%0d overflow_cnt=%0d", fifo_level, overflow_cnt);
        chk("ovf fifo_level", 32'(fifo_level), 32'd8);
        chk("ovf overflow_cnt", 32'(overflow_cnt), 32'd2);
        for (int j = 0; j < 8; j++) begin
            ei = 16'h0100 + 16'(2 * j);
            eq = 16'h0101 + 16'(2 * j);
            $display("drain %0d: i=%04h q=%04h", j, bus.i_out, bus.q_out);
            chk_pair($sformatf("ovf drain%0d", j), xw(ei), xw(eq));
            drive(1'b0, 16'h0000, 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("ovf drained out_valid", 32'(bus.out_valid), 32'd0);
        chk("ovf drained fifo_level", 32'(fifo_level), 32'd0);

        // Full FIFO with a simultaneous pop accepts the new pair
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 16'h0200 + 16'(k), 1'b0, 1'b0);
            tick();
        end
        chk("full fifo_level", 32'(fifo_level), 32'd8);
        drive(1'b1, 16'h02AA, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'h02BB, 1'b0, 1'b1);
        tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        $display("full+pop: level=%0d overflow_cnt=%0d", fifo_level, overflow_cnt);
        chk("fullpop fifo_level", 32'(fifo_level), 32'd8);
        chk("fullpop overflow_cnt", 32'(overflow_cnt), 32'd2);
        for (int j = 0; j < 8; j++) begin
            if (j < 7) begin
                ei = 16'h0200 + 16'(2 * (j + 1));
                eq = 16'h0201 + 16'(2 * (j + 1));
            end else begin
                ei = 16'h02AA;
                eq = 16'h02BB;
            end
            $display("drain %0d: i=%04h q=%04h", j, bus.i_out, bus.q_out);
            chk_pair($sformatf("fullpop drain%0d", j), xw(ei), xw(eq));
            drive(1'b0, 16'h0000, 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("fullpop drained out_valid", 32'(bus.out_valid), 32'd0);

        // Reset mid-stream with 5 pairs stored and an I word pending
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 16'h0300 + 16'(k), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 16'h0777, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("midrst pre fifo_level", 32'(fifo_level), 32'd5);
        #2 reset = 1'b0;
        #1;
        $display("mid reset: out_valid=%0b level=%0d", bus.out_valid, fifo_level);
        chk("midrst fifo_level", 32'(fifo_level), 32'd0);
        chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst overflow_cnt", 32'(overflow_cnt), 32'd0);
        chk("midrst resync_cnt", 32'(resync_cnt), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        drive(1'b1, 16'h000A, 1'b0, 1'b1);
        tick();
        chk("midrst first word out_valid", 32'(bus.out_valid), 32'd0);
        drive(1'b1, 16'h000B, 1'b0, 1'b1);
        tick();
        $display("after reset: i=%04h q=%04h", bus.i_out, bus.q_out);
        chk_pair("midrst pair", xw(16'h000A), xw(16'h000B));
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        chk("midrst popped out_valid", 32'(bus.out_valid), 32'd0);

        // resync_cnt saturates at 255
        drive(1'b1, 16'h0100, 1'b1, 1'b1);
        tick();
        for (int n = 0; n < 300; n++) begin
            drive(1'b1, 16'(n), 1'b1, 1'b1);
            tick();
            if (n == 253) chk("sat resync_cnt 254", 32'(resync_cnt), 32'd254);
        end
        $display("saturation: resync_cnt=%0d", resync_cnt);
        chk("sat resync_cnt", 32'(resync_cnt), 32'd255);
        drive(1'b1, 16'h5555, 1'b0, 1'b1);
        tick();
        chk_pair("sat pair", xw(16'h012B), xw(16'h5555));
        chk("sat resync_cnt held", 32'(resync_cnt), 32'd255);
        chk("sat overflow_cnt", 32'(overflow_cnt), 32'd0);
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        chk("sat popped out_valid", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
